// File: rtl/psum_accum_scheduler.sv
// Feeds one shared psum accumulator from NUM_ROWS PE rows, highest row first,
// and emits one wrapped DWIDTH-bit sum per output pixel over valid/ready.
module psum_accum_scheduler #(
    parameter int DWIDTH   = 8,
    parameter int NUM_ROWS = 3,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [CNT_W-1:0]           cfg_num_out,
    input  logic [NUM_ROWS-1:0]        psum_valid,
    input  logic [NUM_ROWS*DWIDTH-1:0] psum_data,
    output logic [NUM_ROWS-1:0]        psum_ready,
    output logic                       sum_valid,
    output logic [DWIDTH-1:0]          sum_data,
    input  logic                       sum_ready,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           out_count
);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  cur_row_q, cur_row_d;
    logic [DWIDTH-1:0] acc_q, acc_d;
    logic [DWIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0]  cfg_q, cfg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              sel_valid_s;
    logic [DWIDTH-1:0] sel_data_s;
    logic [DWIDTH-1:0] row_sum_s;
    logic [CNT_W-1:0]  cnt_inc_s;

    // Mux out the active row's valid/data and form the running sum
    always_comb begin
        sel_valid_s = 1'b0;
        sel_data_s  = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            sel_valid_s = sel_valid_s | (psum_valid[r] & (cur_row_q == ROW_W'(r)));
            sel_data_s  = sel_data_s
                        | (psum_data[r*DWIDTH +: DWIDTH] & {DWIDTH{cur_row_q == ROW_W'(r)}});
        end
        // The first row of each pixel restarts the accumulator, so no clear cycle is needed
        row_sum_s = (cur_row_q == LAST_ROW) ? sel_data_s : (acc_q + sel_data_s);
        cnt_inc_s = cnt_q + CNT_W'(1);
    end

    // Row accept strobes decoded from state and the current row register
    always_comb begin
        psum_ready = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            psum_ready[r] = (state_q == ST_RUN) && (cur_row_q == ROW_W'(r));
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        cur_row_d = cur_row_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        cfg_d     = cfg_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cfg_d     = cfg_num_out;
                    cnt_d     = '0;
                    cur_row_d = LAST_ROW;
                    if (cfg_num_out != '0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (sel_valid_s) begin
                    acc_d = row_sum_s;
                    if (cur_row_q == '0) begin
                        sum_d   = row_sum_s;
                        state_d = ST_OUT;
                    end else begin
                        cur_row_d = cur_row_q - ROW_W'(1);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_OUT: begin
                if (sum_ready) begin
                    cnt_d     = cnt_inc_s;
                    cur_row_d = LAST_ROW;
                    if (cnt_inc_s == cfg_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cur_row_q <= LAST_ROW;
            acc_q     <= '0;
            sum_q     <= '0;
            cfg_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_row_q <= cur_row_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            cfg_q     <= cfg_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sum_valid = (state_q == ST_OUT);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_OUT);
    assign done      = (state_q == ST_DONE);
    assign sum_data  = sum_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_psum_accum_scheduler.sv
// Bench for psum_accum_scheduler: directed timing cases plus randomized runs,
// with a scoreboard monitor comparing every delivered sum against queued expectations.
module tb_psum_accum_scheduler;
    localparam int DW = 8;
    localparam int NR = 3;
    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic [CW-1:0]  cfg_num_out = '0;
    logic [NR-1:0]  psum_valid = '0;
    logic [NR*DW-1:0] psum_data = '0;
    logic [NR-1:0]  psum_ready;
    logic           sum_valid;
    logic [DW-1:0]  sum_data;
    logic           sum_ready = 1'b0;
    logic           busy;
    logic           done;
    logic [CW-1:0]  out_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;

    psum_accum_scheduler #(.DWIDTH(DW), .NUM_ROWS(NR), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_out(cfg_num_out),
        .psum_valid(psum_valid), .psum_data(psum_data), .psum_ready(psum_ready),
        .sum_valid(sum_valid), .sum_data(sum_data), .sum_ready(sum_ready),
        .busy(busy), .done(done), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: samples just before each rising edge
    always @(negedge clk) begin
        #4;
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            chk("ready_legal", {31'd0, ($countones(psum_ready) <= 1) && !(sum_valid && psum_ready != '0)}, 32'd1);
            if (hold_prev) begin
                chk("hold_valid", {31'd0, sum_valid}, 32'd1);
                chk("hold_data", {24'd0, sum_data}, {24'd0, prev_data});
            end
            if (sum_valid && sum_ready) begin
                if (exp_q.size() == 0) chk("sb_unexpected_output", 32'd1, 32'd0);
                else chk("sb_sum", {24'd0, sum_data}, exp_q.pop_front());
            end
            hold_prev = sum_valid && !sum_ready;
            prev_data = sum_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Random run: psums held per row until accepted, expected sums from plain arithmetic
    task automatic rand_run(input int cfg);
        logic [DW-1:0] vals[8][NR];
        int ptr[NR];
        logic [NR-1:0] hs;
        int s, cyc, dcount;
        bit finished;
        for (int k = 0; k < cfg; k++) begin
            s = 0;
            for (int r = 0; r < NR; r++) begin
                vals[k][r] = DW'($urandom_range(0, 255));
                s += int'(vals[k][r]);
            end
            exp_q.push_back(s % 256);
        end
        for (int r = 0; r < NR; r++) ptr[r] = 0;
        @(negedge clk);
        cfg_num_out = CW'(cfg);
        start = 1'b1;
        cyc = 0; dcount = 0; finished = 1'b0;
        while (!finished && cyc < 3000) begin
            for (int r = 0; r < NR; r++) begin
                psum_valid[r] = (ptr[r] < cfg) && ($urandom_range(0, 99) < 60);
                psum_data[r*DW +: DW] = (ptr[r] < cfg) ? vals[ptr[r]][r] : DW'($urandom_range(0, 255));
            end
            sum_ready = ($urandom_range(0, 99) < 70);
            #4;
            hs = psum_valid & psum_ready;
            for (int r = 0; r < NR; r++) if (hs[r]) ptr[r]++;
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) begin
                dcount++;
                finished = 1'b1;
            end
        end
        chk("rand_finished", {31'd0, finished}, 32'd1);
        chk("rand_out_count", {16'd0, out_count}, cfg);
        chk("rand_all_psums_taken", ptr[0] + ptr[1] + ptr[2], NR * cfg);
        chk("rand_sb_drained", exp_q.size(), 32'd0);
        psum_valid = '0;
        @(negedge clk);
        chk("rand_done_single", {31'd0, done}, 32'd0);
        chk("rand_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int done_cnt;
        // Reset state
        #1 rst_n = 1'b0;
        psum_valid = 3'b111;
        repeat (2) @(negedge clk);
        chk("rst_ready", {29'd0, psum_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", {29'd0, psum_ready}, 32'd0);
        chk("idle_sum_valid", {31'd0, sum_valid}, 32'd0);
        chk("idle_sum_data", {24'd0, sum_data}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_out_count", {16'd0, out_count}, 32'd0);
        psum_valid = '0;

        // Single output, cycle-exact
        @(negedge clk);
        exp_q.push_back(60);
        psum_data = {8'd10, 8'd20, 8'd30};
        psum_valid = 3'b111; sum_ready = 1'b1; cfg_num_out = 16'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("single_ready_c1", {29'd0, psum_ready}, 32'd4);
        @(negedge clk);
        chk("single_ready_c2", {29'd0, psum_ready}, 32'd2);
        @(negedge clk);
        chk("single_ready_c3", {29'd0, psum_ready}, 32'd1);
        @(negedge clk);
        chk("single_valid_c4", {31'd0, sum_valid}, 32'd1);
        chk("single_data_c4", {24'd0, sum_data}, 32'd60);
        @(negedge clk);
        chk("single_done_c5", {31'd0, done}, 32'd1);
        chk("single_count_c5", {16'd0, out_count}, 32'd1);
        chk("single_busy_c5", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("single_done_c6", {31'd0, done}, 32'd0);
        psum_valid = '0;

        // Wrap and strict row ordering
        @(negedge clk);
        exp_q.push_back(54);
        psum_data = {8'd200, 8'd100, 8'd10};
        psum_valid = 3'b001; cfg_num_out = 16'd1; start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk); start = 1'b0;
            if (c <= 5) chk("wrap_row0_blocked", {31'd0, psum_ready[0]}, 32'd0);
            if (c == 4) chk("wrap_ready_row1", {29'd0, psum_ready}, 32'd2);
            if (c == 7) begin
                chk("wrap_valid", {31'd0, sum_valid}, 32'd1);
                chk("wrap_data", {24'd0, sum_data}, 32'd54);
            end
            psum_valid[2] = (c == 3);
            psum_valid[1] = (c == 5);
            psum_valid[0] = (c <= 6);
        end
        repeat (2) @(negedge clk);

        // Backpressure across a two-output run
        exp_q.push_back(24);
        exp_q.push_back(9);
        psum_data = {8'd7, 8'd8, 8'd9};
        psum_valid = 3'b111; sum_ready = 1'b0; cfg_num_out = 16'd2; start = 1'b1;
        done_cnt = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk); start = 1'b0;
            done_cnt += int'(done);
            if (c >= 4 && c <= 8) begin
                chk("bp_valid", {31'd0, sum_valid}, 32'd1);
                chk("bp_data", {24'd0, sum_data}, 32'd24);
                chk("bp_ready", {29'd0, psum_ready}, 32'd0);
            end
            if (c == 13) chk("bp_second_data", {24'd0, sum_data}, 32'd9);
            sum_ready = (c >= 9);
            if (c == 9) psum_data = {8'd250, 8'd10, 8'd5};
        end
        chk("bp_out_count", {16'd0, out_count}, 32'd2);
        chk("bp_done_pulses", done_cnt, 32'd1);
        psum_valid = '0;

        // Reset in the middle of a run
        @(negedge clk);
        psum_data = {8'd1, 8'd1, 8'd1};
        psum_valid = 3'b111; cfg_num_out = 16'd1; start = 1'b1; sum_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {29'd0, psum_ready}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_sum_data", {24'd0, sum_data}, 32'd0);
        chk("mid_rst_out_count", {16'd0, out_count}, 32'd0);
        psum_valid = '0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(6);
        psum_data = {8'd1, 8'd2, 8'd3};
        psum_valid = 3'b111; cfg_num_out = 16'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_data", {24'd0, sum_data}, 32'd6);
        @(negedge clk);
        chk("post_rst_done", {31'd0, done}, 32'd1);
        psum_valid = '0;

        // Zero-length run
        @(negedge clk);
        psum_valid = 3'b111; cfg_num_out = 16'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_ready", {29'd0, psum_ready}, 32'd0);
        chk("zero_out_count", {16'd0, out_count}, 32'd0);
        @(negedge clk);
        chk("zero_done_end", {31'd0, done}, 32'd0);
        chk("zero_busy", {31'd0, busy}, 32'd0);

        // Start pulses while busy (RUN, OUT, DONE) are ignored
        @(negedge clk);
        exp_q.push_back(33);
        psum_data = {8'd11, 8'd11, 8'd11};
        cfg_num_out = 16'd1; start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 5) begin
                chk("busy_start_done", {31'd0, done}, 32'd1);
                chk("busy_start_count", {16'd0, out_count}, 32'd1);
            end
            if (c >= 6) begin
                chk("busy_start_idle", {31'd0, busy}, 32'd0);
                chk("busy_start_no_ready", {29'd0, psum_ready}, 32'd0);
            end
            start = (c == 2) || (c == 4) || (c == 5);
            cfg_num_out = (c >= 2) ? 16'd5 : 16'd1;
        end
        psum_valid = '0;

        // Randomized runs
        for (int i = 0; i < 20; i++) rand_run(int'($urandom_range(1, 5)));

        repeat (3) @(negedge clk);
        chk("final_sb_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
